// File: rtl/sram_axi_arbiter_pkg.sv
// Shared constants, FSM state encoding and write-strobe helper for the
// SRAM-to-AXI arbiter.
package sram_axi_arbiter_pkg;

   localparam logic [3:0] DEF_INST_ID    = 4'd0;
   localparam logic [3:0] DEF_DATA_ID    = 4'd1;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_AR   = 3'd1,
      ST_R    = 3'd2,
      ST_AW_W = 3'd3,
      ST_B    = 3'd4
   } state_e;

   // size 0 byte, 1 half, 2/3 word; lane picked by the low address bits
   function automatic logic [3:0] gen_wstrb(input logic [1:0] size, input logic [1:0] a);
      case (size)
         2'd0:    return 4'b0001 << a;
         2'd1:    return 4'b0011 << {a[1], 1'b0};
         default: return 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/sram_rr_arb.sv
// Two-input round-robin arbiter; bit 0 = inst, bit 1 = data.
// last_grant resets to data so inst wins the first tie.
module sram_rr_arb (
   input  logic       clk,
   input  logic       resetn,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] grant
);

   logic last_data;

   always_comb begin
      grant = 2'b00;
      if (req[0] && (!req[1] || last_data)) grant = 2'b01;
      else if (req[1])                      grant = 2'b10;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                  last_data <= 1'b1;
      else if (accept && |grant)    last_data <= grant[1];
   end

endmodule

// File: rtl/sram_axi_arbiter.sv
// Shares one AXI3 master port between the fetch and data SRAM-like ports.
// Single-beat transfers, one outstanding transaction at a time.
module sram_axi_arbiter
   import sram_axi_arbiter_pkg::*;
#(
   parameter logic [3:0] INST_ID = DEF_INST_ID,
   parameter logic [3:0] DATA_ID = DEF_DATA_ID
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [3:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [3:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic [1:0]  awlock,
   output logic [3:0]  awcache,
   output logic [2:0]  awprot,
   output logic        awvalid,
   input  logic        awready,
   output logic [3:0]  wid,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   input  logic [3:0]  bid,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready,
   output logic        axi_err
);

   state_e      state, state_nx;
   logic        owner;           // 1 = data port owns the transaction
   logic [1:0]  size_q;
   logic [31:0] addr_q, wdata_q;
   logic        aw_done, w_done;
   logic [1:0]  grant;
   logic        idle;
   logic [3:0]  cur_id;
   logic        unused_rlast;

   assign unused_rlast = rlast;
   assign idle         = (state == ST_IDLE);
   assign cur_id       = owner ? DATA_ID : INST_ID;

   sram_rr_arb u_arb (
      .clk    (clk),
      .resetn (resetn),
      .req    ({data_req, inst_req}),
      .accept (idle),
      .grant  (grant)
   );

   assign inst_addr_ok = idle & grant[0];
   assign data_addr_ok = idle & grant[1];

   assign arid    = cur_id;
   assign araddr  = addr_q;
   assign arlen   = 4'd0;
   assign arsize  = {1'b0, size_q};
   assign arburst = AXI_BURST_INCR;
   assign arlock  = 2'b00;
   assign arcache = 4'd0;
   assign arprot  = 3'd0;
   assign awid    = cur_id;
   assign awaddr  = addr_q;
   assign awlen   = 4'd0;
   assign awsize  = {1'b0, size_q};
   assign awburst = AXI_BURST_INCR;
   assign awlock  = 2'b00;
   assign awcache = 4'd0;
   assign awprot  = 3'd0;
   assign wid     = awid;
   assign wdata   = wdata_q;
   assign wstrb   = gen_wstrb(size_q, addr_q[1:0]);
   assign wlast   = 1'b1;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_nx;
   end

   // valids/readies decode straight from state so reset drops them at once
   always_comb begin
      state_nx = state;
      arvalid  = 1'b0;
      rready   = 1'b0;
      awvalid  = 1'b0;
      wvalid   = 1'b0;
      bready   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (inst_addr_ok)      state_nx = ST_AR;
            else if (data_addr_ok) state_nx = data_wr ? ST_AW_W : ST_AR;
         end
         ST_AR: begin
            arvalid = 1'b1;
            if (arready) state_nx = ST_R;
         end
         ST_R: begin
            rready = 1'b1;
            if (rvalid) state_nx = ST_IDLE;
         end
         ST_AW_W: begin
            awvalid = !aw_done;
            wvalid  = !w_done;
            if ((aw_done || awready) && (w_done || wready)) state_nx = ST_B;
         end
         ST_B: begin
            bready = 1'b1;
            if (bvalid) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         owner        <= 1'b0;
         size_q       <= 2'd0;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         aw_done      <= 1'b0;
         w_done       <= 1'b0;
         inst_data_ok <= 1'b0;
         data_data_ok <= 1'b0;
         inst_rdata   <= 32'd0;
         data_rdata   <= 32'd0;
         axi_err      <= 1'b0;
      end else begin
         inst_data_ok <= 1'b0;
         data_data_ok <= 1'b0;
         if (inst_addr_ok) begin
            owner  <= 1'b0;
            size_q <= 2'd2;
            addr_q <= inst_addr;
         end else if (data_addr_ok) begin
            owner   <= 1'b1;
            size_q  <= data_size;
            addr_q  <= data_addr;
            wdata_q <= data_wdata;
         end
         if (idle) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end else begin
            if (awvalid && awready) aw_done <= 1'b1;
            if (wvalid && wready)   w_done  <= 1'b1;
         end
         if (rready && rvalid) begin
            if (owner) begin
               data_rdata   <= rdata;
               data_data_ok <= 1'b1;
            end else begin
               inst_rdata   <= rdata;
               inst_data_ok <= 1'b1;
            end
            if (rresp != 2'b00 || rid != cur_id) axi_err <= 1'b1;
         end
         if (bready && bvalid) begin
            data_data_ok <= 1'b1;
            if (bresp != 2'b00 || bid != cur_id) axi_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sram_axi_arbiter.sv
// Directed self-checking bench for sram_axi_arbiter; the bench plays the AXI slave.
module tb_sram_axi_arbiter;

   logic        clk, resetn;
   logic        inst_req, inst_addr_ok, inst_data_ok;
   logic [31:0] inst_addr, inst_rdata;
   logic        data_req, data_wr, data_addr_ok, data_data_ok;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb, rid, bid;
   logic [31:0] araddr, awaddr, wdata, rdata;
   logic [2:0]  arsize, arprot, awsize, awprot;
   logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready, axi_err;

   int checks = 0;
   int failures = 0;

   sram_axi_arbiter dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready), .axi_err(axi_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic apply_reset;
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({arvalid, awvalid, wvalid, rready, bready, inst_addr_ok, data_addr_ok,
           inst_data_ok, data_data_ok, axi_err} !== 10'd0) begin
         failures++;
         $display("FAIL reset_ctrl: got %b expected 0", {arvalid, awvalid, wvalid, rready, bready,
                  inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, axi_err});
      end
      checks++;
      if ({inst_rdata, data_rdata} !== 64'd0) begin
         failures++;
         $display("FAIL reset_rdata: got %h expected 0", {inst_rdata, data_rdata});
      end
      checks++;
      if ({arlen, awlen, arburst, awburst, arlock, arcache, arprot, wlast} !== {4'd0, 4'd0, 2'b01, 2'b01, 2'b00, 4'd0, 3'd0, 1'b1}) begin
         failures++;
         $display("FAIL const_fields: got %h", {arlen, awlen, arburst, awburst, arlock, arcache, arprot, wlast});
      end
      resetn = 1'b1;
   endtask

   task automatic test_inst_read;
      inst_req = 1'b1; inst_addr = 32'h1000; arready = 1'b1;
      #1;
      checks++;
      if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin
         failures++; $display("FAIL ir_addr_ok: got %b expected 10", {inst_addr_ok, data_addr_ok});
      end
      tick; inst_req = 1'b0;
      checks++;
      if ({arvalid, arid, arsize, arlen} !== {1'b1, 4'd0, 3'd2, 4'd0}) begin
         failures++; $display("FAIL ir_ar_fields: got %h expected %h", {arvalid, arid, arsize, arlen}, {1'b1, 4'd0, 3'd2, 4'd0});
      end
      checks++;
      if (araddr !== 32'h1000) begin
         failures++; $display("FAIL ir_araddr: got %h expected 00001000", araddr);
      end
      tick;
      checks++;
      if ({rready, inst_data_ok} !== 2'b10) begin
         failures++; $display("FAIL ir_rready: got %b expected 10", {rready, inst_data_ok});
      end
      rvalid = 1'b1; rdata = 32'hDEADBEEF; rid = 4'd0; rresp = 2'b00;
      tick; rvalid = 1'b0;
      checks++;
      if ({inst_data_ok, data_data_ok, rready} !== 3'b100) begin
         failures++; $display("FAIL ir_data_ok: got %b expected 100", {inst_data_ok, data_data_ok, rready});
      end
      checks++;
      if (inst_rdata !== 32'hDEADBEEF) begin
         failures++; $display("FAIL ir_rdata: got %h expected deadbeef", inst_rdata);
      end
      tick;
      checks++;
      if (inst_data_ok !== 1'b0) begin
         failures++; $display("FAIL ir_data_ok_pulse: got %b expected 0", inst_data_ok);
      end
   endtask

   task automatic test_round_robin;
      logic [1:0]  exp_ok;
      logic [3:0]  exp_id;
      logic [31:0] exp_addr, exp_data;
      apply_reset;
      inst_req = 1'b1; inst_addr = 32'h1100;
      data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h2000;
      arready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_ok   = (i % 2 == 0) ? 2'b10 : 2'b01;
         exp_id   = (i % 2 == 0) ? 4'd0 : 4'd1;
         exp_addr = (i % 2 == 0) ? 32'h1100 : 32'h2000;
         exp_data = 32'hA000_0000 + i;
         #1;
         checks++;
         if ({inst_addr_ok, data_addr_ok} !== exp_ok) begin
            failures++; $display("FAIL rr_grant%0d: got %b expected %b", i, {inst_addr_ok, data_addr_ok}, exp_ok);
         end
         tick;
         checks++;
         if ({inst_addr_ok, data_addr_ok, arid, araddr} !== {2'b00, exp_id, exp_addr}) begin
            failures++; $display("FAIL rr_ar%0d: got %h expected %h", i, {inst_addr_ok, data_addr_ok, arid, araddr}, {2'b00, exp_id, exp_addr});
         end
         tick;
         rvalid = 1'b1; rid = exp_id; rdata = exp_data; rresp = 2'b00;
         tick; rvalid = 1'b0;
         checks++;
         if ({inst_data_ok, data_data_ok} !== exp_ok) begin
            failures++; $display("FAIL rr_data_ok%0d: got %b expected %b", i, {inst_data_ok, data_data_ok}, exp_ok);
         end
         checks++;
         if (((i % 2 == 0) ? inst_rdata : data_rdata) !== exp_data) begin
            failures++; $display("FAIL rr_rdata%0d: got %h expected %h", i, ((i % 2 == 0) ? inst_rdata : data_rdata), exp_data);
         end
         if (i == 3) begin inst_req = 1'b0; data_req = 1'b0; end
      end
      tick;
      checks++;
      if ({inst_data_ok, data_data_ok, arvalid} !== 3'b000) begin
         failures++; $display("FAIL rr_quiet: got %b expected 000", {inst_data_ok, data_data_ok, arvalid});
      end
   endtask

   task automatic test_byte_write;
      data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_addr = 32'h3003; data_wdata = 32'h5A5A5A5A;
      awready = 1'b1; wready = 1'b1;
      #1;
      checks++;
      if (data_addr_ok !== 1'b1) begin
         failures++; $display("FAIL bw_addr_ok: got %b expected 1", data_addr_ok);
      end
      tick; data_req = 1'b0; data_wr = 1'b0;
      checks++;
      if ({awvalid, wvalid, awsize, wstrb, wlast, awid, wid, awlen} !== {1'b1, 1'b1, 3'd0, 4'b1000, 1'b1, 4'd1, 4'd1, 4'd0}) begin
         failures++; $display("FAIL bw_aw_fields: got %h expected %h", {awvalid, wvalid, awsize, wstrb, wlast, awid, wid, awlen},
                              {1'b1, 1'b1, 3'd0, 4'b1000, 1'b1, 4'd1, 4'd1, 4'd0});
      end
      checks++;
      if ({awaddr, wdata} !== {32'h3003, 32'h5A5A5A5A}) begin
         failures++; $display("FAIL bw_addr_data: got %h expected 000030035a5a5a5a", {awaddr, wdata});
      end
      tick;
      checks++;
      if ({awvalid, wvalid, bready} !== 3'b001) begin
         failures++; $display("FAIL bw_bready: got %b expected 001", {awvalid, wvalid, bready});
      end
      bvalid = 1'b1; bid = 4'd1; bresp = 2'b00;
      tick; bvalid = 1'b0;
      checks++;
      if ({data_data_ok, inst_data_ok, bready} !== 3'b100) begin
         failures++; $display("FAIL bw_data_ok: got %b expected 100", {data_data_ok, inst_data_ok, bready});
      end
      tick;
      checks++;
      if (data_data_ok !== 1'b0) begin
         failures++; $display("FAIL bw_data_ok_pulse: got %b expected 0", data_data_ok);
      end
   endtask

   task automatic test_write_delays;
      // aw handshake late, w immediate
      awready = 1'b0; wready = 1'b1;
      data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h4000; data_wdata = 32'h11223344;
      #1; tick; data_req = 1'b0; data_wr = 1'b0;
      checks++;
      if ({awvalid, wvalid, bready, wstrb} !== {3'b110, 4'b1111}) begin
         failures++; $display("FAIL wd_a_start: got %b expected 1101111", {awvalid, wvalid, bready, wstrb});
      end
      for (int c = 1; c < 3; c++) begin
         tick;
         checks++;
         if ({awvalid, wvalid, bready} !== 3'b100) begin
            failures++; $display("FAIL wd_a_hold%0d: got %b expected 100", c, {awvalid, wvalid, bready});
         end
      end
      awready = 1'b1;
      tick; awready = 1'b0;
      checks++;
      if ({awvalid, wvalid, bready} !== 3'b001) begin
         failures++; $display("FAIL wd_a_b: got %b expected 001", {awvalid, wvalid, bready});
      end
      bvalid = 1'b1; bid = 4'd1; bresp = 2'b00;
      tick; bvalid = 1'b0;
      checks++;
      if (data_data_ok !== 1'b1) begin
         failures++; $display("FAIL wd_a_done: got %b expected 1", data_data_ok);
      end
      // w handshake late, aw immediate; half-word to the upper lane
      awready = 1'b1; wready = 1'b0;
      data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1; data_addr = 32'h4002;
      #1; tick; data_req = 1'b0; data_wr = 1'b0;
      checks++;
      if ({awvalid, wvalid, bready, wstrb} !== {3'b110, 4'b1100}) begin
         failures++; $display("FAIL wd_b_start: got %b expected 1101100", {awvalid, wvalid, bready, wstrb});
      end
      for (int c = 1; c < 3; c++) begin
         tick;
         checks++;
         if ({awvalid, wvalid, bready} !== 3'b010) begin
            failures++; $display("FAIL wd_b_hold%0d: got %b expected 010", c, {awvalid, wvalid, bready});
         end
      end
      wready = 1'b1;
      tick;
      checks++;
      if ({awvalid, wvalid, bready} !== 3'b001) begin
         failures++; $display("FAIL wd_b_b: got %b expected 001", {awvalid, wvalid, bready});
      end
      bvalid = 1'b1;
      tick; bvalid = 1'b0;
      checks++;
      if (data_data_ok !== 1'b1) begin
         failures++; $display("FAIL wd_b_done: got %b expected 1", data_data_ok);
      end
   endtask

   task automatic test_errors;
      checks++;
      if (axi_err !== 1'b0) begin
         failures++; $display("FAIL err_clean: got %b expected 0", axi_err);
      end
      arready = 1'b1;
      data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h5000;
      #1; tick; data_req = 1'b0;
      tick;
      rvalid = 1'b1; rid = 4'd1; rresp = 2'b10; rdata = 32'h12345678;
      tick; rvalid = 1'b0; rresp = 2'b00;
      checks++;
      if ({data_data_ok, axi_err, data_rdata} !== {2'b11, 32'h12345678}) begin
         failures++; $display("FAIL err_rresp: got %h expected 312345678", {data_data_ok, axi_err, data_rdata});
      end
      data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h5004;
      #1; tick; data_req = 1'b0; data_wr = 1'b0;
      tick;
      bvalid = 1'b1; bid = 4'd3; bresp = 2'b00;
      tick; bvalid = 1'b0; bid = 4'd1;
      checks++;
      if ({data_data_ok, axi_err} !== 2'b11) begin
         failures++; $display("FAIL err_bid: got %b expected 11", {data_data_ok, axi_err});
      end
      tick;
      checks++;
      if (axi_err !== 1'b1) begin
         failures++; $display("FAIL err_sticky: got %b expected 1", axi_err);
      end
   endtask

   task automatic test_reset_mid;
      arready = 1'b0;
      inst_req = 1'b1; inst_addr = 32'h6000;
      #1; tick; inst_req = 1'b0;
      checks++;
      if (arvalid !== 1'b1) begin
         failures++; $display("FAIL rm_in_ar: got %b expected 1", arvalid);
      end
      #1 resetn = 1'b0;
      #1;
      checks++;
      if ({arvalid, axi_err} !== 2'b00) begin
         failures++; $display("FAIL rm_async_drop: got %b expected 00", {arvalid, axi_err});
      end
      arready = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick;
         checks++;
         if ({inst_data_ok, data_data_ok, arvalid} !== 3'b000) begin
            failures++; $display("FAIL rm_held%0d: got %b expected 000", c, {inst_data_ok, data_data_ok, arvalid});
         end
      end
      resetn = 1'b1;
      inst_req = 1'b1;
      #1;
      checks++;
      if (inst_addr_ok !== 1'b1) begin
         failures++; $display("FAIL rm_reaccept: got %b expected 1", inst_addr_ok);
      end
      tick; inst_req = 1'b0;
      checks++;
      if ({arvalid, araddr} !== {1'b1, 32'h6000}) begin
         failures++; $display("FAIL rm_ar: got %h expected 100006000", {arvalid, araddr});
      end
      tick;
      rvalid = 1'b1; rid = 4'd0; rresp = 2'b00; rdata = 32'hCAFEF00D;
      tick; rvalid = 1'b0;
      checks++;
      if ({inst_data_ok, inst_rdata} !== {1'b1, 32'hCAFEF00D}) begin
         failures++; $display("FAIL rm_read: got %h expected 1cafef00d", {inst_data_ok, inst_rdata});
      end
   endtask

   initial begin
      resetn = 1'b0;
      inst_req = 1'b0; inst_addr = 32'd0;
      data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'd0; data_wdata = 32'd0;
      arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;
      awready = 1'b0; wready = 1'b0; bid = 4'd0; bresp = 2'b00; bvalid = 1'b0;
      test_reset;
      test_inst_read;
      test_round_robin;
      test_byte_write;
      test_write_delays;
      test_errors;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
